// File: rtl/vn_lut_rd_ctrl_pkg.sv
// Shared definitions for the VN lookup-table read controller.
// The read latency constant follows the VN_LUT_OUT_REG_EN build macro.
package vn_lut_rd_ctrl_pkg;

  // Default geometry: 32-entry LUT of 3-bit quantised VN messages
  localparam int VN_ADDR_W = 5;
  localparam int VN_DATA_W = 3;

  // Cycles from request acceptance to rsp_valid
`ifdef VN_LUT_OUT_REG_EN
  localparam int VN_RD_LATENCY = 3;
`else
  localparam int VN_RD_LATENCY = 2;
`endif

  // Controller states: only RUN accepts lookups
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } vn_state_t;

  // True when the post-increment write counter says the last entry was written.
  // The counter carries one extra bit, so its MSB flags the end of the table.
  function automatic logic vn_load_last(input logic [VN_ADDR_W:0] cnt_after);
    return cnt_after[VN_ADDR_W];
  endfunction

endpackage

// File: rtl/vn_lut_pipe_port.sv
// One LUT read port: stage 1 registers valid+address, stage 2 registers the
// LUT word; with VN_LUT_OUT_REG_EN an extra output register stage follows.
// Response data holds its last value whenever the response valid is low.
module vn_lut_pipe_port
  import vn_lut_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W = VN_ADDR_W,
  parameter int DATA_W = VN_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              pipe_busy
);

  logic              s1_valid_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic              s2_valid_reg;
  logic [DATA_W-1:0] s2_data_reg;

  // Stage 1 captures the accepted request, stage 2 captures the LUT word
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s1_valid_reg <= req_valid;
      if (req_valid) begin
        s1_addr_reg <= req_addr;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= lut_data;
      end
    end
  end

  assign lut_addr = s1_addr_reg;

`ifdef VN_LUT_OUT_REG_EN
  logic              s3_valid_reg;
  logic [DATA_W-1:0] s3_data_reg;

  // Optional output register stage for timing closure on the response path
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid_reg <= 1'b0;
      s3_data_reg  <= '0;
    end else begin
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s3_data_reg <= s2_data_reg;
      end
    end
  end

  assign rsp_valid = s3_valid_reg;
  assign rsp_data  = s3_data_reg;
  assign pipe_busy = s1_valid_reg | s2_valid_reg | s3_valid_reg;
`else
  assign rsp_valid = s2_valid_reg;
  assign rsp_data  = s2_data_reg;
  assign pipe_busy = s1_valid_reg | s2_valid_reg;
`endif

endmodule

// File: rtl/vn_lut_rd_ctrl.sv
// VN LUT read controller: a 2**ADDR_W x DATA_W register-array LUT loaded
// sequentially from address 0, read through two independent pipelined ports.
// A reload requested while running first drains in-flight reads so they see
// the old table. Build macro VN_LUT_OUT_REG_EN adds a third read stage.
module vn_lut_rd_ctrl
  import vn_lut_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W = VN_ADDR_W,
  parameter int DATA_W = VN_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_done,
  input  logic              req_valid_A,
  input  logic              req_valid_B,
  input  logic [ADDR_W-1:0] page_addr_A,
  input  logic [ADDR_W-1:0] page_addr_B,
  output logic              req_ready,
  output logic              rsp_valid_A,
  output logic              rsp_valid_B,
  output logic [DATA_W-1:0] rsp_data_A,
  output logic [DATA_W-1:0] rsp_data_B,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  vn_state_t         state_reg;
  logic [ADDR_W:0]   wr_cnt_reg;
  logic [ADDR_W:0]   wr_cnt_next;
  logic              load_done_reg;
  logic              run_reg;
  logic              lut_we;

  logic [DATA_W-1:0] lut_mem [DEPTH];

  logic [1:0]        port_accept;
  logic [1:0]        port_rsp_valid;
  logic [1:0]        port_busy;
  logic [ADDR_W-1:0] port_lut_addr [2];
  logic [DATA_W-1:0] port_lut_data [2];
  logic [DATA_W-1:0] port_rsp_data [2];

  assign wr_cnt_next = wr_cnt_reg + CNT_ONE;
  assign lut_we      = (state_reg == ST_LOAD) && load_valid;

  // A reload request closes the request window in the same cycle
  assign req_ready = run_reg && !load_start;
  assign busy      = !run_reg;
  assign load_done = load_done_reg;

  // Control FSM with registered run flag and load_done pulse
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      wr_cnt_reg    <= '0;
      load_done_reg <= 1'b0;
      run_reg       <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_start) begin
            state_reg  <= ST_LOAD;
            wr_cnt_reg <= '0;
          end
        end
        ST_LOAD: begin
          // load_start is deliberately ignored here: no counter restart
          if (load_valid) begin
            wr_cnt_reg <= wr_cnt_next;
            if (vn_load_last(wr_cnt_next)) begin
              state_reg     <= ST_RUN;
              run_reg       <= 1'b1;
              load_done_reg <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Writes may only start once no read can still sample the old table
          if (port_busy == 2'b00) begin
            state_reg  <= ST_LOAD;
            wr_cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          if (load_start) begin
            state_reg <= ST_DRAIN;
            run_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          run_reg   <= 1'b0;
        end
      endcase
    end
  end

  // LUT write port; table contents survive reset
  always_ff @(posedge sys_clk) begin
    if (lut_we) begin
      lut_mem[wr_cnt_reg[ADDR_W-1:0]] <= load_data;
    end
  end

  assign port_accept[0] = req_valid_A && req_ready;
  assign port_accept[1] = req_valid_B && req_ready;

  // Two identical read ports, each with its own LUT read mux
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_lut_data[gi] = lut_mem[port_lut_addr[gi]];

      vn_lut_pipe_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_pipe_port (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .req_valid (port_accept[gi]),
        .req_addr  ((gi == 0) ? page_addr_A : page_addr_B),
        .lut_addr  (port_lut_addr[gi]),
        .lut_data  (port_lut_data[gi]),
        .rsp_valid (port_rsp_valid[gi]),
        .rsp_data  (port_rsp_data[gi]),
        .pipe_busy (port_busy[gi])
      );
    end
  endgenerate

  assign rsp_valid_A = port_rsp_valid[0];
  assign rsp_valid_B = port_rsp_valid[1];
  assign rsp_data_A  = port_rsp_data[0];
  assign rsp_data_B  = port_rsp_data[1];

endmodule

// File: tb/tb_vn_lut_rd_ctrl.sv
// Self-checking bench for vn_lut_rd_ctrl. The reference model keeps a plain
// array for the table, a run/loading flag pair, and per-port queues of
// expected responses stamped with the cycle they must appear.
// Honours VN_LUT_OUT_REG_EN for the expected read latency.
module tb_vn_lut_rd_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 3;
  localparam int DEPTH = 32;
`ifdef VN_LUT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rsp_t;

  logic          sys_clk = 1'b0;
  logic          rstn = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_done;
  logic          req_valid_A = 1'b0;
  logic          req_valid_B = 1'b0;
  logic [AW-1:0] page_addr_A = '0;
  logic [AW-1:0] page_addr_B = '0;
  logic          req_ready;
  logic          rsp_valid_A;
  logic          rsp_valid_B;
  logic [DW-1:0] rsp_data_A;
  logic [DW-1:0] rsp_data_B;
  logic          busy;

  vn_lut_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .req_valid_A (req_valid_A),
    .req_valid_B (req_valid_B),
    .page_addr_A (page_addr_A),
    .page_addr_B (page_addr_B),
    .req_ready   (req_ready),
    .rsp_valid_A (rsp_valid_A),
    .rsp_valid_B (rsp_valid_B),
    .rsp_data_A  (rsp_data_A),
    .rsp_data_B  (rsp_data_B),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            exp_run = 1'b0;
  bit            loading = 1'b0;
  int            n_wr = 0;
  logic [DW-1:0] model_lut [DEPTH];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  rsp_t          qa[$];
  rsp_t          qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic set_quiet();
    load_start  = 1'b0;
    load_valid  = 1'b0;
    req_valid_A = 1'b0;
    req_valid_B = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    bit   rdy;
    bit   done_next;
    rsp_t r;
    #1;
    rdy = exp_run && !load_start;
    chk("req_ready", req_ready, rdy);
    chk("busy", busy, !exp_run);
    if (rdy && req_valid_A) begin
      r.due = cyc + LAT; r.data = model_lut[page_addr_A]; qa.push_back(r);
    end
    if (rdy && req_valid_B) begin
      r.due = cyc + LAT; r.data = model_lut[page_addr_B]; qb.push_back(r);
    end
    done_next = 1'b0;
    if (loading) begin
      if (load_valid) begin
        model_lut[n_wr] = load_data;
        n_wr++;
        if (n_wr == DEPTH) begin
          loading   = 1'b0;
          exp_run   = 1'b1;
          done_next = 1'b1;
        end
      end
    end else if (load_start) begin
      loading = 1'b1;
      n_wr    = 0;
      exp_run = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("load_done", load_done, done_next);
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("rsp_valid_A", rsp_valid_A, 1);
      chk("rsp_data_A", rsp_data_A, qa[0].data);
      $display("cyc %0d rsp A data=%0d", cyc, rsp_data_A);
      last_a = qa[0].data;
      void'(qa.pop_front());
    end else begin
      chk("rsp_valid_A_idle", rsp_valid_A, 0);
      chk("rsp_data_A_hold", rsp_data_A, last_a);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("rsp_valid_B", rsp_valid_B, 1);
      chk("rsp_data_B", rsp_data_B, qb[0].data);
      $display("cyc %0d rsp B data=%0d", cyc, rsp_data_B);
      last_b = qb[0].data;
      void'(qb.pop_front());
    end else begin
      chk("rsp_valid_B_idle", rsp_valid_B, 0);
      chk("rsp_data_B_hold", rsp_data_B, last_b);
    end
  endtask

  task automatic idle(input int n);
    set_quiet();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_quiet();
    #1;
    chk("rst_rsp_valid_A", rsp_valid_A, 0);
    chk("rst_rsp_valid_B", rsp_valid_B, 0);
    chk("rst_rsp_data_A", rsp_data_A, 0);
    chk("rst_rsp_data_B", rsp_data_B, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    qa.delete();
    qb.delete();
    exp_run = 1'b0;
    loading = 1'b0;
    n_wr    = 0;
    last_a  = '0;
    last_b  = '0;
    for (int i = 0; i < 2; i++) cycle();
    rstn = 1'b1;
    $display("cyc %0d reset released", cyc);
  endtask

  // Stream n table writes; mode 0 = (i mod 8), otherwise random with gaps.
  // restart_at >= 0 pulses load_start mid-load, which must be ignored.
  task automatic load_entries(input int n, input int mode, input int restart_at);
    int i;
    i = 0;
    while (i < n) begin
      set_quiet();
      load_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      load_data  = (mode == 0) ? DW'(i % 8) : DW'($urandom_range(0, 7));
      if (i == restart_at) load_start = 1'b1;
      cycle();
      if (load_valid) i++;
    end
    set_quiet();
  endtask

  task automatic start_load();
    set_quiet();
    load_start = 1'b1;
    cycle();
    idle(6);
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      set_quiet();
      req_valid_A = $urandom_range(0, 1);
      req_valid_B = $urandom_range(0, 1);
      page_addr_A = AW'($urandom_range(0, DEPTH - 1));
      page_addr_B = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle(LAT + 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_lut[i] = 'x;
    #2;
    do_reset();

    // Initial load with (i mod 8) pattern
    $display("step: initial load");
    start_load();
    load_entries(DEPTH, 0, -1);
    idle(2);

    // Simultaneous lookups on both ports
    $display("step: A=5 B=13");
    set_quiet();
    req_valid_A = 1'b1; page_addr_A = 5;
    req_valid_B = 1'b1; page_addr_B = 13;
    cycle();
    idle(4);

    // Back-to-back stream on port A, random traffic on B
    $display("step: A sweep 0..31");
    for (int i = 0; i < DEPTH; i++) begin
      set_quiet();
      req_valid_A = 1'b1;
      page_addr_A = AW'(i);
      req_valid_B = $urandom_range(0, 1);
      page_addr_B = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle(LAT + 1);

    // Stray load_valid while running must not touch the table
    $display("step: stray load_valid in RUN");
    for (int i = 0; i < 3; i++) begin
      set_quiet();
      load_valid = 1'b1;
      load_data  = DW'($urandom_range(0, 7));
      cycle();
    end
    rand_reads(20);

    // Reload right behind an in-flight read of addr 7
    $display("step: reload behind addr 7 read");
    set_quiet();
    req_valid_A = 1'b1; page_addr_A = 7;
    cycle();
    set_quiet();
    load_start  = 1'b1;
    req_valid_A = 1'b1; page_addr_A = 9;
    req_valid_B = 1'b1; page_addr_B = 7;
    cycle();
    idle(6);
    load_entries(DEPTH, 1, 15);
    rand_reads(40);

    // Reset after 10 writes, then a clean reload
    $display("step: reset mid-load");
    start_load();
    load_entries(10, 1, -1);
    do_reset();
    idle(3);
    start_load();
    load_entries(DEPTH, 1, -1);
    rand_reads(150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vn_lut_rd_ctrl.md
VN_LUT_RD_CTRL -- requirements
Module: vn_lut_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, page-address width (LUT depth 2**ADDR_W = 32).
REQ-002 SHALL have parameter DATA_W, default 3, quantised VN output message width.
REQ-003 SHALL have sys_clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have load_start  input  1  one-cycle pulse requesting a full LUT (re)load.
REQ-006 SHALL have load_valid  input  1  load_data qualifier.
REQ-007 SHALL have load_data  input  DATA_W  LUT entry, written at sequential addresses from 0.
REQ-008 SHALL have load_done  output  1  one-cycle pulse after the last entry is written.
REQ-009 SHALL have req_valid_A / req_valid_B  input  1  port A / B lookup request.
REQ-010 SHALL have page_addr_A / page_addr_B  input  ADDR_W  lookup address from the vn_addr_bus stage.
REQ-011 SHALL have req_ready  output  1  both ports may issue this cycle.
REQ-012 SHALL have rsp_valid_A / rsp_valid_B  output  1  response qualifier per port.
REQ-013 SHALL have rsp_data_A / rsp_data_B  output  DATA_W  LUT contents at the requested address.
REQ-014 SHALL have busy  output  1  high in any state other than RUN.

Function
REQ-015 SHALL hold a 2**ADDR_W x DATA_W register-array LUT with two independent read ports and one write port.
REQ-016 SHALL implement FSM states IDLE, LOAD, DRAIN, RUN.
REQ-017 IDLE: req_ready=0; load_start -> LOAD, write counter cleared to 0.
REQ-018 LOAD: each load_valid writes load_data at counter, counter+1; the write at address 2**ADDR_W-1 -> RUN with load_done pulsed the following cycle; load_valid outside LOAD ignored.
REQ-019 RUN: req_ready=1; on a port whose req_valid is high while req_ready=1 the request is accepted; ports independent, same address on both allowed.
REQ-020 Read latency SHALL be exactly 2 cycles from acceptance to rsp_valid (stage 1 registers address+valid, stage 2 registers LUT data); fully pipelined, one request per port per cycle.
REQ-021 load_start in RUN: req_ready drops the same cycle; -> DRAIN; DRAIN -> LOAD once both pipeline stages are empty; in-flight responses SHALL return old LUT contents.
REQ-022 load_start in LOAD or DRAIN SHALL be ignored (no counter restart).
REQ-023 Counter SHALL be ADDR_W+1 bits wide so the end of load is detected without wrap ambiguity.
REQ-024 rsp_data SHALL hold the last value when rsp_valid=0.

Reset
REQ-025 rstn low SHALL force state IDLE, counter 0, pipeline valids 0, rsp_valid_A/B 0, rsp_data_A/B 0, load_done 0, req_ready 0, busy 1; LUT contents are not reset.
REQ-026 Reset mid-LOAD or mid-pipeline SHALL discard all partial progress; a fresh load_start is required.

Configuration
REQ-027 Macro VN_LUT_OUT_REG_EN defined: an extra output register stage; latency 3 cycles; DRAIN waits for all three stages empty.
REQ-028 Macro undefined: latency 2 cycles as REQ-020.

Structure
REQ-029 A shared package SHALL hold ADDR_W/DATA_W defaults, the FSM state encoding and the latency constant.
REQ-030 One sub-module vn_lut_pipe_port SHALL implement a single read port's valid/address/data pipeline, instantiated twice.

Verification
REQ-031 Reset then load entries 0..31 with value (i mod 8) -> load_done pulses once 1 cycle after the 32nd write; req_ready=1, busy=0.
REQ-032 RUN, A addr 5, B addr 13 same cycle -> 2 cycles later rsp_valid_A=rsp_valid_B=1, data 5 and 5.
REQ-033 Back-to-back A requests addr 0..31 every cycle -> 32 consecutive responses in order, no bubbles.
REQ-034 load_start one cycle after a request to addr 7 -> old value returned for addr 7, req_ready low until the new load_done, new values read afterwards.
REQ-035 rstn asserted after 10 load writes -> IDLE, all outputs at reset values; reload completes normally.
REQ-036 With VN_LUT_OUT_REG_EN, repeat REQ-032 -> responses 3 cycles after acceptance.
